// File: rtl/path_pkg.sv
// rtl/path_pkg.sv - shared constants and helpers for the path merge units and their arbiter
//
// Holds the word width and burst quota defaults shared by path and path_arbiter,
// an index-width helper, and a one-hot decoder sized for the largest arbiter.

package path_pkg;

    // Defaults shared with the path merge unit.
    localparam int DWIDTH_DEF = 8;
    localparam int BURST_DEF  = 10;

    // Widest requester vector any arbiter instance may have.
    localparam int MAX_REQ = 8;

    // Number of bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // One-hot decode of a unit index; callers cast the result down to NREQ bits.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search over a request vector
//
// Scans indices start+1 .. start+N-1 (modulo N) and returns the first one whose
// request bit is set. The start index itself is never selected, so a scheduler
// can ask "who else wants the resource" without masking its current owner.
//
// Ports:
//   req    in  N   request vector
//   start  in  IW  index the scan starts after
//   found  out 1   at least one other index is requesting
//   idx    out IW  first requesting index after start (start when none found)

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // One extra bit so start+i cannot overflow before the modulo wrap.
    logic [IW:0] k;

    always_comb begin
        found = 1'b0;
        idx   = start;
        k     = '0;
        for (int i = 1; i < N; i++) begin
            k = {1'b0, start} + (IW+1)'(i);
            if (k >= (IW+1)'(N)) begin
                k = k - (IW+1)'(N);
            end
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                idx   = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/path_arbiter.sv
// rtl/path_arbiter.sv - round-robin burst arbiter merging NREQ path units onto one output
//
// Issues a registered one-hot grant to one path unit at a time, counts words
// transferred in the current tenure, rotates to the next requester after BURST
// words or when the owner stops requesting, and forwards the owner's word two
// cycles after its transfer. Any valid_i that does not match the expected
// returning word sets a sticky error.
//
// Ports:
//   clk      in  1             clock, rising edge
//   rst_n    in  1             asynchronous active-low reset
//   req_i    in  NREQ          per-unit request
//   valid_i  in  NREQ          per-unit word valid (one cycle after transfer)
//   data_i   in  NREQ*DWIDTH   per-unit words, slice k = [k*DWIDTH +: DWIDTH]
//   stall_i  in  1             consumer back-pressure, blocks new grants
//   gnt_o    out NREQ          registered one-hot grant or zero
//   data_o   out DWIDTH        registered output word
//   valid_o  out 1             registered output valid
//   src_o    out clog2(NREQ)   unit that produced data_o
//   err_o    out 1             sticky protocol error

module path_arbiter
    import path_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int BURST  = BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          valid_i,
    input  logic [NREQ*DWIDTH-1:0]   data_i,
    input  logic                     stall_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [DWIDTH-1:0]        data_o,
    output logic                     valid_o,
    output logic [clog2(NREQ)-1:0]   src_o,
    output logic                     err_o
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(BURST);

    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            exp_q;
    logic [IW-1:0]   exp_src_q;

    logic            xfer;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] gnt_next;
    logic [NREQ-1:0] exp_mask;
    logic [DWIDTH-1:0] word_sel;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req_i),
        .start (owner),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A word moves exactly when the registered grant meets the owner's request;
    // the path unit reads its FIFO (or bypasses) in this same cycle.
    assign xfer = gnt_o[owner] & req_i[owner];

    // Tenure bookkeeping. A full quota always starts a new tenure, even when no
    // one else is waiting; an idle owner yields only if someone else wants in,
    // otherwise the grant stays parked so an empty path can still bypass.
    always_comb begin
        owner_n = owner;
        cnt_n   = cnt;
        if (xfer) begin
            if (cnt == CW'(BURST - 1)) begin
                cnt_n = '0;
                if (pick_found) begin
                    owner_n = pick_idx;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (!req_i[owner] && pick_found) begin
            owner_n = pick_idx;
            cnt_n   = '0;
        end
    end

    assign gnt_next = NREQ'(onehot(3'(owner_n)));

    // The only legal valid_i pattern is the returning word of last cycle's transfer.
    assign exp_mask = exp_q ? NREQ'(onehot(3'(exp_src_q))) : '0;

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (exp_src_q == IW'(k)) begin
                word_sel = data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            cnt       <= '0;
            gnt_o     <= '0;
            exp_q     <= 1'b0;
            exp_src_q <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            src_o     <= '0;
            err_o     <= 1'b0;
        end else begin
            owner     <= owner_n;
            cnt       <= cnt_n;
            // Stall only withholds the next grant; words already transferred
            // keep flowing through exp_q to the output.
            gnt_o     <= stall_i ? '0 : gnt_next;
            exp_q     <= xfer;
            exp_src_q <= owner;
            if (exp_q && valid_i[exp_src_q]) begin
                data_o  <= word_sel;
                valid_o <= 1'b1;
                src_o   <= exp_src_q;
            end else begin
                valid_o <= 1'b0;
            end
            err_o     <= err_o | (valid_i != exp_mask);
        end
    end

endmodule

// File: tb/tb_path_arbiter.sv
// tb/tb_path_arbiter.sv - directed self-checking bench for path_arbiter

module tb_path_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req_i = '0;
    logic [3:0]      valid_i = '0;
    logic [31:0]     data_i = '0;
    logic            stall_i = 1'b0;
    logic [3:0]      gnt_o;
    logic [7:0]      data_o;
    logic            valid_o;
    logic [1:0]      src_o;
    logic            err_o;

    path_arbiter #(
        .NREQ   (NREQ),
        .DWIDTH (DW),
        .BURST  (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .stall_i (stall_i),
        .gnt_o   (gnt_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .src_o   (src_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int data;
        int c;
    } sb_t;

    int        n_cmp = 0;
    int        n_err = 0;
    int        cyc_n = 0;
    int        n_deliv = 0;
    int        last_data = 0;
    int        rem [4];
    int        word [4];
    logic [3:0] en = '0;
    int        xlog [$];
    sb_t       sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req();
        for (int k = 0; k < 4; k++) begin
            req_i[k] = en[k] && (rem[k] > 0);
        end
    endtask

    // One clock of the path-unit model: a transfer seen before the edge returns
    // its word on valid_i/data_i in the following cycle.
    task automatic cyc();
        logic [3:0] xf;
        sb_t e;
        xf = gnt_o & req_i;
        @(posedge clk);
        #1;
        cyc_n++;
        if (valid_o) begin
            n_deliv++;
            last_data = int'(data_o);
            if (sb.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data", data_o, e.data[7:0]);
                check("src", src_o, e.src);
                check("latency", cyc_n - e.c, 32'd2);
            end
        end
        valid_i = '0;
        data_i  = $urandom();
        for (int k = 0; k < 4; k++) begin
            if (xf[k]) begin
                valid_i[k]          = 1'b1;
                data_i[k*DW +: DW]  = word[k][7:0];
                sb.push_back('{k, word[k] & 255, cyc_n - 1});
                xlog.push_back(k);
                word[k]++;
                rem[k]--;
            end
        end
        set_req();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_i   = '0;
        valid_i = '0;
        stall_i = 1'b0;
        data_i  = '0;
        en      = '0;
        for (int k = 0; k < 4; k++) begin
            rem[k]  = 0;
            word[k] = 0;
        end
        sb.delete();
        xlog.delete();
        n_deliv = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        en = '0;
        set_req();
        repeat (3) cyc();
        check({tag, "_drain"}, sb.size(), 32'd0);
        check({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        int ord3 [4];
        ord3 = '{0, 1, 3, 0};

        // Reset release, no requests: grant parks on unit 0.
        do_reset();
        check("t1_gnt_in_reset", gnt_o, 4'b0000);
        check("t1_valid_in_reset", valid_o, 1'b0);
        cyc();
        check("t1_gnt_first", gnt_o, 4'b0001);
        repeat (3) cyc();
        check("t1_gnt_parked", gnt_o, 4'b0001);
        check("t1_valid", valid_o, 1'b0);
        check("t1_err", err_o, 1'b0);

        // Single requester streams 0x10..0x1B and re-tenures after 10 words.
        xlog.delete();
        n_deliv  = 0;
        en       = 4'b0010;
        rem[1]   = 12;
        word[1]  = 8'h10;
        set_req();
        cyc();
        check("t2_gnt_move", gnt_o, 4'b0010);
        repeat (20) cyc();
        check("t2_xfers", xlog.size(), 32'd12);
        for (int i = 0; i < xlog.size(); i++) begin
            check("t2_src_log", xlog[i], 32'd1);
        end
        check("t2_delivered", n_deliv, 32'd12);
        check("t2_last_word", last_data, 32'h1B);
        check("t2_gnt_park", gnt_o, 4'b0010);
        drain("t2");

        // Three continuous requesters rotate 0,1,3,0 with 10 transfers each.
        do_reset();
        en = 4'b1011;
        rem[0] = 100; rem[1] = 100; rem[3] = 100;
        word[0] = 8'h00; word[1] = 8'h40; word[3] = 8'hC0;
        set_req();
        repeat (42) cyc();
        check("t3_count", xlog.size() >= 40, 1'b1);
        for (int i = 0; i < 40 && i < xlog.size(); i++) begin
            check("t3_order", xlog[i], ord3[i/10]);
        end
        drain("t3");

        // Owner drops after 3 words; unit 2 takes over with a fresh quota.
        do_reset();
        en = 4'b1101;
        rem[0] = 3; rem[2] = 100; rem[3] = 100;
        word[0] = 8'h01; word[2] = 8'h80; word[3] = 8'hE0;
        set_req();
        repeat (4) cyc();
        check("t4_req0_dropped", req_i[0], 1'b0);
        cyc();
        check("t4_gnt_switch", gnt_o, 4'b0100);
        repeat (12) cyc();
        check("t4_count", xlog.size() >= 14, 1'b1);
        for (int i = 0; i < 14 && i < xlog.size(); i++) begin
            check("t4_order", xlog[i], (i < 3) ? 0 : (i < 13) ? 2 : 3);
        end
        drain("t4");

        // Stall mid-burst: grant drops one cycle later, quota resumes after release.
        do_reset();
        en = 4'b0110;
        rem[1] = 100; rem[2] = 100;
        word[1] = 8'h20; word[2] = 8'hA0;
        set_req();
        repeat (5) cyc();
        stall_i = 1'b1;
        cyc();
        check("t5_gnt_stalled", gnt_o, 4'b0000);
        check("t5_xfers_at_stall", xlog.size(), 32'd5);
        repeat (4) cyc();
        check("t5_gnt_still_stalled", gnt_o, 4'b0000);
        check("t5_inflight_done", sb.size(), 32'd0);
        stall_i = 1'b0;
        cyc();
        check("t5_gnt_resume", gnt_o, 4'b0010);
        repeat (8) cyc();
        check("t5_count", xlog.size() >= 13, 1'b1);
        for (int i = 0; i < 13 && i < xlog.size(); i++) begin
            check("t5_order", xlog[i], (i < 10) ? 1 : 2);
        end
        drain("t5");

        // Protocol fault sets sticky error; reset mid-burst clears everything.
        do_reset();
        en = 4'b0010;
        rem[1] = 100;
        word[1] = 8'h30;
        set_req();
        repeat (2) cyc();
        check("t6_err_before", err_o, 1'b0);
        valid_i[3] = 1'b1;
        cyc();
        check("t6_err_set", err_o, 1'b1);
        repeat (3) cyc();
        check("t6_err_sticky", err_o, 1'b1);
        check("t6_valid_mid", valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt_o, 4'b0000);
        check("t6_rst_valid", valid_o, 1'b0);
        check("t6_rst_data", data_o, 8'h00);
        check("t6_rst_src", src_o, 2'd0);
        check("t6_rst_err", err_o, 1'b0);
        en = '0;
        set_req();
        valid_i = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        check("t6_gnt_restart", gnt_o, 4'b0001);
        check("t6_valid_after", valid_o, 1'b0);
        check("t6_err_after", err_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
